// File: rtl/ooo_sram_pkg.sv
// Shared types for the two-port SRAM array model: clear-sequencer state encoding
// and default geometry used by the cache data/tag arrays.
package ooo_sram_pkg;

   typedef enum logic {SRAM_INIT, SRAM_READY} sram_state_t;

   localparam int SRAM_DEF_DATA_WIDTH = 256;
   localparam int SRAM_DEF_ADDR_WIDTH = 4;
   localparam int SRAM_DEF_MASK_GRAN  = 8;

endpackage

// File: rtl/ooo_sram_2p_array_if.sv
// Request/response bundle of the two-port SRAM array: port 0 read/write with lane
// mask, port 1 read-only, plus the ready flag raised once the array is usable.
interface ooo_sram_2p_array_if #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 4,
   parameter int MASK_GRAN  = 8
);
   localparam int NUM_WMASKS = DATA_WIDTH / MASK_GRAN;

   logic                  ready;
   logic                  csb0;
   logic                  web0;
   logic [NUM_WMASKS-1:0] wmask0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [DATA_WIDTH-1:0] din0;
   logic [DATA_WIDTH-1:0] dout0;
   logic                  csb1;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] dout1;

   modport master (
      input  ready, dout0, dout1,
      output csb0, web0, wmask0, addr0, din0, csb1, addr1
   );

   modport slave (
      output ready, dout0, dout1,
      input  csb0, web0, wmask0, addr0, din0, csb1, addr1
   );

endinterface

// File: rtl/ooo_sram_init_seq.sv
// Post-reset clear sequencer: walks every address once writing zero, then parks in
// READY until the next reset. With INIT_ON_RESET=0 it comes out of reset already READY.
module ooo_sram_init_seq
   import ooo_sram_pkg::*;
#(
   parameter int ADDR_WIDTH    = 4,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ready,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   sram_state_t           state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= (INIT_ON_RESET != 0) ? SRAM_INIT : SRAM_READY;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // NOTE: every output of this block gets a default first so no path can leave
   // a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_we    = 1'b0;
      unique case (state)
         SRAM_INIT: begin
            clr_we  = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == {ADDR_WIDTH{1'b1}}) state_nxt = SRAM_READY;
         end
         SRAM_READY: ;
         default: state_nxt = SRAM_INIT;
      endcase
   end

   assign ready    = (state == SRAM_READY);
   assign clr_addr = cnt;

endmodule

// File: rtl/ooo_sram_2p_array.sv
// Two-port SRAM array model: port 0 read/write with lane masking, port 1 read-only,
// registered read data, zero-clear after reset and optional same-edge write bypass on port 1.
module ooo_sram_2p_array #(
   parameter int DATA_WIDTH    = 256,
   parameter int ADDR_WIDTH    = 4,
   parameter int MASK_GRAN     = 8,
   parameter int INIT_ON_RESET = 1,
   parameter int BYPASS        = 1
) (
   input  logic                clk,
   input  logic                rst,
   ooo_sram_2p_array_if.slave  bus
);

   localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
   localparam int NUM_WMASKS = DATA_WIDTH / MASK_GRAN;

   logic                  ready;
   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;

   ooo_sram_init_seq #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .INIT_ON_RESET (INIT_ON_RESET)
   ) u_init_seq (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   logic p0_rd, p0_wr, p1_rd;

   // Requests are only honoured once the clear pass has finished.
   assign p0_rd = ready & ~bus.csb0 &  bus.web0;
   assign p0_wr = ready & ~bus.csb0 & ~bus.web0;
   assign p1_rd = ready & ~bus.csb1;

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NUM_WMASKS-1:0] wr_mask;

   always_comb begin
      wr_en   = p0_wr;
      wr_addr = bus.addr0;
      wr_data = bus.din0;
      wr_mask = bus.wmask0;
      if (clr_we) begin
         wr_en   = 1'b1;
         wr_addr = clr_addr;
         wr_data = '0;
         wr_mask = '1;
      end
   end

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   // NOTE: the storage array has no reset term; clearing is done by the sequencer
   // through the normal write port so it maps onto a plain SRAM macro.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wr_mask[i]) mem[wr_addr][i*MASK_GRAN +: MASK_GRAN] <= wr_data[i*MASK_GRAN +: MASK_GRAN];
         end
      end
   end

   logic [DATA_WIDTH-1:0] rd1_word;

   generate
      if (BYPASS != 0) begin : g_bypass
         logic [DATA_WIDTH-1:0] merged;
         always_comb begin
            merged = mem[bus.addr1];
            for (int i = 0; i < NUM_WMASKS; i++) begin
               if (bus.wmask0[i]) merged[i*MASK_GRAN +: MASK_GRAN] = bus.din0[i*MASK_GRAN +: MASK_GRAN];
            end
            rd1_word = (p0_wr && (bus.addr0 == bus.addr1)) ? merged : mem[bus.addr1];
         end
      end else begin : g_no_bypass
         assign rd1_word = mem[bus.addr1];
      end
   endgenerate

   logic [DATA_WIDTH-1:0] dout0_q, dout1_q;

   // Deselected ports and port-0 write cycles keep the last read value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout0_q <= '0;
         dout1_q <= '0;
      end else begin
         if (p0_rd) dout0_q <= mem[bus.addr0];
         if (p1_rd) dout1_q <= rd1_word;
      end
   end

   assign bus.ready = ready;
   assign bus.dout0 = dout0_q;
   assign bus.dout1 = dout1_q;

endmodule
